// File: rtl/filtro_pkg.sv
// Shared constants for the 2nd-order IIR datapath: default widths, coefficient ROM,
// saturation bounds and the operand-bank decode used by the MAC.
package filtro_pkg;

  localparam int W_DEF    = 16;
  localparam int CW_DEF   = 16;
  localparam int FRAC_DEF = 14;

  // Q2.14 FIR smoothing default; feedback taps (3,4) are stored pre-negated.
  localparam logic signed [CW_DEF-1:0] COEF_ROM [5] = '{
    16'sh1000, 16'sh2000, 16'sh1000, 16'sh0000, 16'sh0000
  };

  localparam logic signed [W_DEF-1:0] SAT_MAX = 16'sh7FFF;
  localparam logic signed [W_DEF-1:0] SAT_MIN = 16'sh8000;

  typedef enum logic [1:0] {
    BANK_X    = 2'd0,
    BANK_Y    = 2'd1,
    BANK_NONE = 2'd2
  } bank_e;

  function automatic bank_e bank_of(input logic [2:0] sel);
    if (sel <= 3'd2)      return BANK_X;
    else if (sel <= 3'd4) return BANK_Y;
    else                  return BANK_NONE;
  endfunction

endpackage

// File: rtl/filtro_sat.sv
// Combinational output stage: arithmetic shift by FRAC (toward -inf) and clip
// from the accumulator width down to a W-bit sample, flagging any clipping.
module filtro_sat
  import filtro_pkg::*;
#(
  parameter int W     = W_DEF,
  parameter int ACC_W = W_DEF + CW_DEF + 3,
  parameter int FRAC  = FRAC_DEF
) (
  input  logic signed [ACC_W-1:0] acc_in,
  output logic signed [W-1:0]     y_sat,
  output logic                    clip
);

  localparam logic signed [ACC_W-1:0] MAX_EXT = {{(ACC_W-W+1){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] MIN_EXT = {{(ACC_W-W+1){1'b1}}, {(W-1){1'b0}}};
  localparam logic signed [W-1:0]     Y_MAX   = {1'b0, {(W-1){1'b1}}};
  localparam logic signed [W-1:0]     Y_MIN   = {1'b1, {(W-1){1'b0}}};

  // Returns {clip, sample}.
  function automatic logic [W:0] shift_clip(input logic signed [ACC_W-1:0] a);
    logic signed [ACC_W-1:0] s;
    s = a >>> FRAC;
    if (s > MAX_EXT)      return {1'b1, Y_MAX};
    else if (s < MIN_EXT) return {1'b1, Y_MIN};
    else                  return {1'b0, s[W-1:0]};
  endfunction

  always_comb begin
    {clip, y_sat} = shift_clip(acc_in);
  end

endmodule

// File: rtl/filtro_mac.sv
// MAC datapath of the 2nd-order IIR filter, driven step-by-step by the sequencer.
// Optional `FILTRO_COEF_LOAD_EN makes the coefficients run-time writable registers.
module filtro_mac
  import filtro_pkg::*;
#(
  parameter int W     = W_DEF,
  parameter int CW    = CW_DEF,
  parameter int FRAC  = FRAC_DEF,
  parameter int ACC_W = W + CW + 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic signed [W-1:0]  muestra_in,
  input  logic                 muestra_valida,
  input  logic [2:0]           Sel_cons,
  input  logic [1:0]           Sel_fk,
  input  logic                 Sel_ac,
  input  logic                 listo,
  input  logic                 paso,
`ifdef FILTRO_COEF_LOAD_EN
  input  logic                 coef_we,
  input  logic [2:0]           coef_addr,
  input  logic signed [CW-1:0] coef_data,
`endif
  output logic signed [W-1:0]  y_out,
  output logic                 y_valida,
  output logic                 sat
);

  logic signed [W-1:0]     x0, x1, x2, y1, y2;
  logic signed [ACC_W-1:0] acc;
  logic signed [W-1:0]     operand;
  logic signed [CW-1:0]    coef_cur;
  logic signed [W+CW-1:0]  prod;
  logic signed [ACC_W-1:0] sum;
  logic signed [W-1:0]     y_sat;
  logic                    clip;
  logic                    fin;

`ifdef FILTRO_COEF_LOAD_EN
  logic signed [CW-1:0] coef_q [5];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 5; i++) coef_q[i] <= CW'(COEF_ROM[i]);
    end else if (coef_we && coef_addr < 3'd5) begin
      coef_q[coef_addr] <= coef_data;
    end
  end

  always_comb begin
    coef_cur = '0;
    if (Sel_cons < 3'd5) coef_cur = coef_q[Sel_cons];
  end
`else
  always_comb begin
    coef_cur = '0;
    if (Sel_cons < 3'd5) coef_cur = CW'(COEF_ROM[Sel_cons]);
  end
`endif

  always_comb begin
    operand = '0;
    case (bank_of(Sel_cons))
      BANK_X: begin
        case (Sel_fk)
          2'd0:    operand = x0;
          2'd1:    operand = x1;
          2'd2:    operand = x2;
          default: operand = '0;
        endcase
      end
      BANK_Y: begin
        case (Sel_fk)
          2'd1:    operand = y1;
          2'd2:    operand = y2;
          default: operand = '0;
        endcase
      end
      default: operand = '0;
    endcase
  end

  assign prod = operand * coef_cur;
  assign sum  = (Sel_ac ? acc : '0) + ACC_W'(prod);
  assign fin  = paso & listo;

  filtro_sat #(
    .W     (W),
    .ACC_W (ACC_W),
    .FRAC  (FRAC)
  ) u_sat (
    .acc_in (sum),
    .y_sat  (y_sat),
    .clip   (clip)
  );

  // Register stage: accumulator, sample history and the output sample.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc      <= '0;
      x0       <= '0;
      x1       <= '0;
      x2       <= '0;
      y1       <= '0;
      y2       <= '0;
      y_out    <= '0;
      y_valida <= 1'b0;
      sat      <= 1'b0;
    end else begin
      y_valida <= fin;
      sat      <= fin & clip;
      if (paso) acc <= sum;
      if (fin) begin
        y_out <= y_sat;
        y1    <= y_sat;
        y2    <= y1;
      end
      if (muestra_valida) begin
        x0 <= muestra_in;
        x1 <= x0;
        x2 <= x1;
      end
    end
  end

endmodule

// File: doc/filtro_mac.md
Name: filtro_mac

Overview:
- Arithmetic datapath of the 2nd-order IIR filter, directly downstream of the filter sequencer.
- Consumes the sequencer's select outputs: coefficient index, operand index, accumulate/clear and last-step flag.
- Performs one signed multiply-accumulate per step and keeps the x/y sample history.
- Emits one saturated output sample per completed sequence, toward the DAC/output stage.

Parameters:
- W, 16: sample width, signed two's complement.
- CW, 16: coefficient width, signed.
- FRAC, 14: fractional bits of coefficients (Q2.14 at default).
- ACC_W, W+CW+3: accumulator width; 3 guard bits cover 5 products.

Ports:
- clk  in  1  system clock, all state on rising edge.
- reset  in  1  synchronous, active-high reset.
- muestra_in  in  W  new input sample x[k].
- muestra_valida  in  1  one-cycle strobe; captures muestra_in into the x history.
- Sel_cons  in  3  coefficient index 0..4; 5..7 invalid.
- Sel_fk  in  2  operand index within the selected bank.
- Sel_ac  in  1  0 = accumulator loads product; 1 = accumulator adds product.
- listo  in  1  current step is the last of the sequence.
- paso  in  1  step strobe; one MAC executes only in cycles where paso=1.
- y_out  out  W  filtered sample, registered.
- y_valida  out  1  one-cycle pulse, y_out updated.
- sat  out  1  with y_valida: y_out was clipped.

Behaviour:
- Reset: acc, x1, x2 (x[k-1], x[k-2]), x0, y1, y2, y_out all 0; y_valida=0; sat=0. Reset overrides every other input in the same cycle.
- Operand mux, combinational:
  - Sel_cons 0..2 selects the x bank: Sel_fk 0→x0, 1→x1, 2→x2, 3→0.
  - Sel_cons 3..4 selects the y bank: Sel_fk 1→y1, 2→y2, 0/3→0.
  - Sel_cons 5..7: product forced to 0.
- Coefficient c[Sel_cons] comes from the package ROM. Feedback coefficients are stored pre-negated, so the datapath only adds.
- Product: signed W x CW, full width W+CW, sign-extended to ACC_W.
- sum = (Sel_ac ? acc : 0) + product. Computed combinationally; acc <= sum on a paso cycle, unchanged otherwise.
- paso & listo in cycle N:
  - scaled = sum >>> FRAC (arithmetic shift, truncation toward −inf).
  - Saturate to [−2^(W−1), 2^(W−1)−1].
  - In cycle N+1: y_out holds the result, y_valida=1, sat=1 if clipped (else 0). One cycle latency from the last step.
  - Same edge: y2 <= y1, y1 <= saturated result.
- muestra_valida: x0 <= muestra_in, x1 <= x0, x2 <= x1.
- Simultaneous muestra_valida and paso: the MAC uses pre-shift history values; the shift lands on the same edge.
- listo without paso: ignored, no output.
- y_valida and sat are 0 in every cycle not following paso&listo. y_out holds its value between updates.
- Reset mid-sequence: partial accumulation is discarded. The next sequence must start with Sel_ac=0.
- No internal FSM beyond the history/accumulator registers. Sequencing authority stays with the sequencer.

Optional Feature:
- Macro FILTRO_COEF_LOAD_EN.
- Defined:
  - Adds ports coef_we (in 1), coef_addr (in 3), coef_data (in CW).
  - The 5 coefficients live in registers, reset to the package ROM values.
  - coef_we writes index coef_addr (0..4; 5..7 ignored) on the next edge.
  - A write in the same cycle as a MAC reading that index: the MAC uses the old value.
- Undefined: coefficients are constants from the package ROM and the extra ports do not exist.

Decomposition:
- Package filtro_pkg holds:
  - W/CW/FRAC defaults.
  - Coefficient ROM, 5 entries: c0=0x1000, c1=0x2000, c2=0x1000, c3=0x0000, c4=0x0000 (FIR smoothing default).
  - Saturation min/max constants.
- One sub-module: filtro_sat. Combinational shift-and-clip from ACC_W to W, with a clip flag.

Test Plan:
- Reset check: assert reset over a busy sequence → next cycle y_out=0, y_valida=0, sat=0, acc and history all 0.
- Impulse, default ROM:
  - Drive x = 0x4000, 0, 0, 0, each followed by sequence (0,0,ac0), (1,1), (2,2), (3,1), (4,2, listo).
  - Expect y_out = 0x1000, 0x2000, 0x1000, 0x0000, each with y_valida one cycle after listo.
- Gapped paso: same as the impulse test but insert idle cycles (paso=0, listo=1 on some) → identical outputs, no spurious y_valida.
- Same-cycle shift: muestra_valida coincides with the first paso of a sequence → products use the pre-shift x0; the new sample appears in the next sequence.
- FILTRO_COEF_LOAD_EN:
  - Load c0=0x7FFF, others 0; x=0x7FFF → y_out=0x7FFF, sat=1.
  - Then x=0x8000 → y_out=0x8000, sat=1.
  - Then c0=0x4000, x=0x1234 → y_out=0x1234, sat=0.
- Feedback: load c3=0x2000 (0.5), c0=0x4000; impulse 0x4000 → y_out = 0x4000, 0x2000, 0x1000, 0x0800.
